// File: rtl/spi_pkg.sv
// Shared SPI definitions used by both the master and the peripheral endpoint.
package spi_pkg;

  // Frame length and synchronizer depth shared with the master side.
  localparam int SPI_DATA_WIDTH  = 8;
  localparam int SPI_SYNC_STAGES = 2;

  // Frame state of the peripheral: deselected or inside a chip-select window.
  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACTIVE = 1'b1
  } spi_state_e;

  // Rising-edge pulse from the current and previous level of a synchronized signal.
  function automatic logic edge_rise(input logic level, input logic hist);
    return level & ~hist;
  endfunction

  // Falling-edge pulse from the current and previous level of a synchronized signal.
  function automatic logic edge_fall(input logic level, input logic hist);
    return ~level & hist;
  endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// N-stage synchronizer for one asynchronous pin, with one history flop
// producing single-cycle rise and fall pulses in the local clock domain.
module spi_sync_edge
  import spi_pkg::*;
#(
  parameter int   STAGES    = 2,
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic async_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);

  logic [STAGES-1:0] sync_q;
  logic              hist_q;

  // Shift the pin through the synchronizer chain and remember the previous output.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      sync_q <= {STAGES{RESET_VAL}};
      hist_q <= RESET_VAL;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], async_i};
      hist_q <= sync_q[STAGES-1];
    end
  end

  assign level_o = sync_q[STAGES-1];
  assign rise_o  = edge_rise(sync_q[STAGES-1], hist_q);
  assign fall_o  = edge_fall(sync_q[STAGES-1], hist_q);

endmodule

// File: rtl/spi_slave.sv
// Mode-0, MSB-first SPI peripheral. Oversamples sclk/chip_select/mosi in the
// local clock domain, assembles received frames into rx_data and serves miso
// from a single-entry transmit buffer.
module spi_slave
  import spi_pkg::*;
#(
  parameter int DATA_WIDTH  = SPI_DATA_WIDTH,
  parameter int SYNC_STAGES = SPI_SYNC_STAGES
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  sclk,
  input  logic                  chip_select,
  input  logic                  mosi,
  output logic                  miso,
  input  logic [DATA_WIDTH-1:0] tx_data,
  input  logic                  tx_load,
  output logic                  tx_ready,
  output logic [DATA_WIDTH-1:0] rx_data,
  output logic                  rx_valid,
  output logic                  busy,
  output logic                  tx_underrun
);

  localparam int                CNT_W    = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DATA_WIDTH - 1);
  localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);

  // Synchronized pin views.
  logic sclk_level_unused_s, sclk_rise_s, sclk_fall_s;
  logic cs_level_s, cs_rise_s, cs_fall_s;
  logic mosi_s, mosi_rise_unused_s, mosi_fall_unused_s;

  // State registers and their next-state values.
  spi_state_e            state_q, state_d;
  logic [DATA_WIDTH-1:0] tx_shift_q, tx_shift_d;
  logic [DATA_WIDTH-1:0] tx_buf_q, tx_buf_d;
  logic                  tx_ready_q, tx_ready_d;
  logic                  underrun_q, underrun_d;
  logic [DATA_WIDTH-1:0] rx_shift_q, rx_shift_d;
  logic [DATA_WIDTH-1:0] rx_data_q, rx_data_d;
  logic                  rx_valid_q, rx_valid_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  reload_q, reload_d;
  logic                  miso_q, miso_d;
  logic                  busy_q, busy_d;

  // Decoded events for the current cycle.
  logic load_accept_s;
  logic frame_begin_s;
  logic frame_end_s;
  logic reload_s;
  logic byte_start_s;
  logic bit_rise_s;
  logic shift_fall_s;

  spi_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sclk (
    .clk_i   (clk),
    .reset_i (reset),
    .async_i (sclk),
    .level_o (sclk_level_unused_s),
    .rise_o  (sclk_rise_s),
    .fall_o  (sclk_fall_s)
  );

  spi_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_cs (
    .clk_i   (clk),
    .reset_i (reset),
    .async_i (chip_select),
    .level_o (cs_level_s),
    .rise_o  (cs_rise_s),
    .fall_o  (cs_fall_s)
  );

  spi_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_mosi (
    .clk_i   (clk),
    .reset_i (reset),
    .async_i (mosi),
    .level_o (mosi_s),
    .rise_o  (mosi_rise_unused_s),
    .fall_o  (mosi_fall_unused_s)
  );

  // Decode frame and bit events; a chip_select rise overrides any sclk edge in the same cycle.
  always_comb begin
    load_accept_s = tx_load & tx_ready_q;
    frame_begin_s = (state_q == ST_IDLE) & cs_fall_s;
    frame_end_s   = (state_q == ST_ACTIVE) & cs_rise_s;
    reload_s      = (state_q == ST_ACTIVE) & ~cs_rise_s & reload_q & sclk_fall_s;
    byte_start_s  = frame_begin_s | reload_s;
    bit_rise_s    = (state_q == ST_ACTIVE) & ~cs_rise_s & sclk_rise_s;
    shift_fall_s  = (state_q == ST_ACTIVE) & ~cs_rise_s & ~reload_q & sclk_fall_s;
  end

  // Frame state transitions.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (cs_fall_s) begin
          state_d = ST_ACTIVE;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ACTIVE: begin
        if (cs_rise_s) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_ACTIVE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Transmit buffer, handshake and underrun flag; an accepted load always wins over setting underrun.
  always_comb begin
    tx_buf_d   = tx_buf_q;
    tx_ready_d = tx_ready_q;
    underrun_d = underrun_q;
    if (load_accept_s) begin
      tx_buf_d   = tx_data;
      tx_ready_d = 1'b0;
      underrun_d = 1'b0;
    end else if (byte_start_s) begin
      if (tx_ready_q) begin
        underrun_d = 1'b1;
      end else begin
        tx_ready_d = 1'b1;
      end
    end else begin
      tx_buf_d = tx_buf_q;
    end
  end

  // Transmit shift register: load at byte start, shift on sclk falls, clear on frame end.
  always_comb begin
    tx_shift_d = tx_shift_q;
    if (frame_end_s) begin
      tx_shift_d = '0;
    end else if (byte_start_s) begin
      if (tx_ready_q) begin
        tx_shift_d = '0;
      end else begin
        tx_shift_d = tx_buf_q;
      end
    end else if (shift_fall_s) begin
      tx_shift_d = {tx_shift_q[DATA_WIDTH-2:0], 1'b0};
    end else begin
      tx_shift_d = tx_shift_q;
    end
    if (state_d == ST_ACTIVE) begin
      miso_d = tx_shift_d[DATA_WIDTH-1];
    end else begin
      miso_d = 1'b0;
    end
  end

  // Receive path: sample mosi on sclk rises, publish a full frame, discard partial frames.
  always_comb begin
    rx_shift_d = rx_shift_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = 1'b0;
    cnt_d      = cnt_q;
    reload_d   = reload_q;
    if (frame_end_s || frame_begin_s) begin
      rx_shift_d = '0;
      cnt_d      = '0;
      reload_d   = 1'b0;
    end else if (bit_rise_s) begin
      rx_shift_d = {rx_shift_q[DATA_WIDTH-2:0], mosi_s};
      if (cnt_q == CNT_LAST) begin
        rx_data_d  = {rx_shift_q[DATA_WIDTH-2:0], mosi_s};
        rx_valid_d = 1'b1;
        cnt_d      = '0;
        reload_d   = 1'b1;
      end else begin
        cnt_d = cnt_q + CNT_ONE;
      end
    end else if (reload_s) begin
      reload_d = 1'b0;
    end else begin
      reload_d = reload_q;
    end
    busy_d = ~cs_level_s;
  end

  // Register frame state, datapath and all outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      tx_shift_q <= '0;
      tx_buf_q   <= '0;
      tx_ready_q <= 1'b1;
      underrun_q <= 1'b0;
      rx_shift_q <= '0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      cnt_q      <= '0;
      reload_q   <= 1'b0;
      miso_q     <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      tx_shift_q <= tx_shift_d;
      tx_buf_q   <= tx_buf_d;
      tx_ready_q <= tx_ready_d;
      underrun_q <= underrun_d;
      rx_shift_q <= rx_shift_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      cnt_q      <= cnt_d;
      reload_q   <= reload_d;
      miso_q     <= miso_d;
      busy_q     <= busy_d;
    end
  end

  assign miso        = miso_q;
  assign tx_ready    = tx_ready_q;
  assign rx_data     = rx_data_q;
  assign rx_valid    = rx_valid_q;
  assign busy        = busy_q;
  assign tx_underrun = underrun_q;

endmodule

// File: tb/tb_spi_slave.sv
// Directed bench for spi_slave: a behavioural mode-0 master drives frames,
// expected rx bytes go into a scoreboard queue checked by an rx_valid monitor.
module tb_spi_slave;

  localparam int HALF = 8;

  logic       clk = 1'b0;
  logic       reset;
  logic       sclk;
  logic       chip_select;
  logic       mosi;
  logic       miso;
  logic [7:0] tx_data;
  logic       tx_load;
  logic       tx_ready;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       busy;
  logic       tx_underrun;

  int         n_checks  = 0;
  int         n_fail    = 0;
  int         rx_pulses = 0;
  logic [7:0] exp_q[$];
  logic [7:0] exp_b;
  logic [7:0] got, got2;

  spi_slave #(.DATA_WIDTH(8), .SYNC_STAGES(2)) dut (
    .clk         (clk),
    .reset       (reset),
    .sclk        (sclk),
    .chip_select (chip_select),
    .mosi        (mosi),
    .miso        (miso),
    .tx_data     (tx_data),
    .tx_load     (tx_load),
    .tx_ready    (tx_ready),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .busy        (busy),
    .tx_underrun (tx_underrun)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  // Scoreboard monitor: every rx_valid pulse must match the oldest expected byte.
  always @(negedge clk) begin
    if (reset === 1'b0 && rx_valid === 1'b1) begin
      rx_pulses++;
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL rx_unexpected: got rx_valid with rx_data 0x%0h, expected no byte", rx_data);
      end else begin
        exp_b = exp_q.pop_front();
        if (rx_data !== exp_b) begin
          n_fail++;
          $display("FAIL rx_data_sb: got 0x%0h, expected 0x%0h", rx_data, exp_b);
        end
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic load_byte(input logic [7:0] b);
    tx_data = b;
    tx_load = 1'b1;
    cyc(1);
    tx_load = 1'b0;
  endtask

  task automatic frame_start();
    chip_select = 1'b0;
    cyc(6);
  endtask

  // Master model: drive nbits MSB-first, sample miso just before each rise.
  // Ending the frame raises chip_select together with the last sclk fall.
  task automatic spi_bits(input logic [7:0] m_tx, input int nbits, input bit end_frame,
                          input bit mid_load, input logic [7:0] mid_val,
                          output logic [7:0] m_rx);
    logic [7:0] data;
    m_rx = 8'h00;
    data = m_tx;
    for (int i = 0; i < nbits; i++) begin
      mosi = data[7-i];
      cyc(HALF);
      m_rx = {m_rx[6:0], miso};
      sclk = 1'b1;
      if (mid_load && i == 7) begin
        cyc(5);
        load_byte(mid_val);
        cyc(HALF - 6);
      end else begin
        cyc(HALF);
      end
      sclk = 1'b0;
      if (end_frame && i == nbits - 1) chip_select = 1'b1;
    end
    mosi = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, expected test completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1; sclk = 1'b0; chip_select = 1'b1; mosi = 1'b0;
    tx_load = 1'b0; tx_data = 8'h00;
    cyc(3);
    check("rst_miso", miso, 0);
    check("rst_rx_data", rx_data, 0);
    check("rst_rx_valid", rx_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_tx_ready", tx_ready, 1);
    check("rst_underrun", tx_underrun, 0);
    reset = 1'b0;
    cyc(4);

    // Basic transfer
    load_byte(8'hA5);
    check("basic_ready_low", tx_ready, 0);
    frame_start();
    check("basic_busy", busy, 1);
    exp_q.push_back(8'h3C);
    spi_bits(8'h3C, 8, 1'b1, 1'b0, 8'h00, got);
    cyc(8);
    check("basic_master_rx", got, 8'hA5);
    check("basic_rx_data", rx_data, 8'h3C);
    check("basic_tx_ready", tx_ready, 1);
    check("basic_underrun", tx_underrun, 0);
    check("basic_busy_end", busy, 0);
    check("basic_rx_pulses", rx_pulses, 1);

    // Back-to-back bytes
    load_byte(8'h11);
    frame_start();
    exp_q.push_back(8'hF0);
    exp_q.push_back(8'h0F);
    spi_bits(8'hF0, 8, 1'b0, 1'b1, 8'h22, got);
    spi_bits(8'h0F, 8, 1'b1, 1'b0, 8'h00, got2);
    cyc(8);
    check("b2b_master_rx0", got, 8'h11);
    check("b2b_master_rx1", got2, 8'h22);
    check("b2b_rx_pulses", rx_pulses, 3);
    check("b2b_rx_data", rx_data, 8'h0F);
    check("b2b_underrun", tx_underrun, 0);

    // Underrun
    frame_start();
    exp_q.push_back(8'h81);
    spi_bits(8'h81, 8, 1'b1, 1'b0, 8'h00, got);
    cyc(8);
    check("udr_master_rx", got, 8'h00);
    check("udr_flag", tx_underrun, 1);
    check("udr_rx_data", rx_data, 8'h81);
    load_byte(8'h5A);
    check("udr_cleared", tx_underrun, 0);
    check("udr_ready_low", tx_ready, 0);

    // Ignored load and idle sclk
    load_byte(8'h77);
    for (int k = 0; k < 3; k++) begin
      sclk = 1'b1; cyc(HALF);
      sclk = 1'b0; cyc(HALF);
    end
    check("idle_rx_pulses", rx_pulses, 4);
    check("idle_busy", busy, 0);
    check("idle_miso", miso, 0);

    // Abort after 5 bits; partial miso bits must come from 0x5A, not 0x77
    frame_start();
    spi_bits(8'hFF, 5, 1'b1, 1'b0, 8'h00, got);
    cyc(8);
    check("abort_partial_miso", got, 8'h0B);
    check("abort_rx_pulses", rx_pulses, 4);
    check("abort_rx_data", rx_data, 8'h81);
    check("abort_miso", miso, 0);
    check("abort_busy", busy, 0);
    check("abort_tx_ready", tx_ready, 1);

    load_byte(8'hC3);
    frame_start();
    exp_q.push_back(8'h96);
    spi_bits(8'h96, 8, 1'b1, 1'b0, 8'h00, got);
    cyc(8);
    check("post_abort_master_rx", got, 8'hC3);
    check("post_abort_rx_data", rx_data, 8'h96);
    check("post_abort_rx_pulses", rx_pulses, 5);

    // Reset mid-frame with the buffer full
    load_byte(8'hE7);
    frame_start();
    load_byte(8'h3E);
    check("rmf_ready_low", tx_ready, 0);
    spi_bits(8'h00, 3, 1'b0, 1'b0, 8'h00, got);
    reset = 1'b1;
    #1;
    check("rmf_miso", miso, 0);
    check("rmf_rx_data", rx_data, 0);
    check("rmf_rx_valid", rx_valid, 0);
    check("rmf_busy", busy, 0);
    check("rmf_tx_ready", tx_ready, 1);
    check("rmf_underrun", tx_underrun, 0);
    chip_select = 1'b1;
    cyc(4);
    reset = 1'b0;
    cyc(8);
    check("rmf_busy_after", busy, 0);
    check("rmf_rx_pulses", rx_pulses, 5);
    check("sb_queue_empty", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
